// File: rtl/regfile_sb.sv
// regfile_sb: parametrised ID-stage register file.
// Two registered read ports with write-through bypass, an optional
// hard-wired zero register, and a per-register busy scoreboard that tells
// the hazard unit which registers still have a result in flight.
//
// Handshake note: writereg and issue_valid are plain strobes with no ready
// (the register file accepts every strobe on the rising edge it is sampled).
// An issue and a write to the same register on one edge leave it busy,
// because the newly issued producer now owns that register.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              writereg,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_en;
  logic              iss_en;
  logic              rs1_zero;
  logic              rs2_zero;

  // Qualify write/issue strobes and zero-register reads.
  always_comb begin
    wr_en    = writereg    && !((ZERO_REG != 0) && (rd == '0));
    iss_en   = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));
    rs1_zero = (ZERO_REG != 0) && (rs1 == '0);
    rs2_zero = (ZERO_REG != 0) && (rs2 == '0);
  end

  // Next-state storage: at most one entry changes per cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (rd == ADDR_W'(i))) begin
        mem_d[i] = writedata;
      end
    end
  end

  // Next-state scoreboard: clear on write first, then set on issue so the set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[rd] = 1'b0;
    end
    if (iss_en) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Storage and scoreboard registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Registered read ports sample next-state values, giving write-through for free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata1 <= '0;
      readdata2 <= '0;
      busy1     <= 1'b0;
      busy2     <= 1'b0;
    end else begin
      readdata1 <= rs1_zero ? '0 : mem_d[rs1];
      readdata2 <= rs2_zero ? '0 : mem_d[rs2];
      busy1     <= busy_d[rs1];
      busy2     <= busy_d[rs2];
    end
  end

endmodule
